// File: rtl/ps2_command_out.sv
// ps2_command_out: PS/2 host-to-device command transmitter.
// Open-drain clock/data with inhibit, request-to-send, shift-out and ACK check.
module ps2_command_out #(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int START_TIMEOUT  = 750000,
    parameter int XFER_TIMEOUT   = 100000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic [7:0] the_command,
    input  logic       send_command,
    inout  wire        PS2_CLK,
    inout  wire        PS2_DAT,
    output logic       busy,
    output logic       command_was_sent,
    output logic       error_communication_timed_out
);

    localparam int MAX_A   = (INHIBIT_CYCLES > START_TIMEOUT) ? INHIBIT_CYCLES : START_TIMEOUT;
    localparam int MAX_LIM = (MAX_A > XFER_TIMEOUT) ? MAX_A : XFER_TIMEOUT;
    localparam int CW      = $clog2(MAX_LIM + 1);

    localparam logic [CW-1:0] INH_LAST   = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] START_LAST = CW'(START_TIMEOUT - 1);
    localparam logic [CW-1:0] XFER_LAST  = CW'(XFER_TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_INHIBIT    = 3'd1;
    localparam logic [2:0] S_RTS        = 3'd2;
    localparam logic [2:0] S_WAIT_START = 3'd3;
    localparam logic [2:0] S_SHIFT      = 3'd4;
    localparam logic [2:0] S_WAIT_ACK   = 3'd5;
    localparam logic [2:0] S_WAIT_IDLE  = 3'd6;
    localparam logic [2:0] S_ERROR      = 3'd7;

    logic [2:0]             state;
    logic [CW-1:0]          cnt;
    logic [3:0]             bit_idx;
    logic [7:0]             cmd_q;
    logic                   parity_q;
    logic                   clk_low;
    logic                   dat_low;
    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] dat_sync;
    logic                   clk_prev;
    logic                   clk_s;
    logic                   dat_s;
    logic                   clk_fall;
    logic                   frame_bit;

    // Open-drain: a logic 1 is always a released line.
    assign PS2_CLK = clk_low ? 1'b0 : 1'bz;
    assign PS2_DAT = dat_low ? 1'b0 : 1'bz;

    assign clk_s    = clk_sync[SYNC_STAGES-1];
    assign dat_s    = dat_sync[SYNC_STAGES-1];
    assign clk_fall = clk_prev & ~clk_s;

    assign frame_bit = (bit_idx == 4'd8) ? parity_q : cmd_q[bit_idx[2:0]];

    // Idle-high reset values keep a spurious falling edge out of reset.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            clk_sync <= '1;
            dat_sync <= '1;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], PS2_CLK};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], PS2_DAT};
            clk_prev <= clk_s;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state                         <= S_IDLE;
            cnt                           <= '0;
            bit_idx                       <= '0;
            cmd_q                         <= '0;
            parity_q                      <= 1'b0;
            clk_low                       <= 1'b0;
            dat_low                       <= 1'b0;
            busy                          <= 1'b0;
            command_was_sent              <= 1'b0;
            error_communication_timed_out <= 1'b0;
        end else begin
            command_was_sent              <= 1'b0;
            error_communication_timed_out <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (send_command) begin
                        cmd_q    <= the_command;
                        parity_q <= ~^the_command;
                        busy     <= 1'b1;
                        clk_low  <= 1'b1;
                        dat_low  <= 1'b0;
                        cnt      <= '0;
                        state    <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    if (cnt == INH_LAST) begin
                        cnt     <= '0;
                        dat_low <= 1'b1;
                        state   <= S_RTS;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_RTS: begin
                    clk_low <= 1'b0;
                    cnt     <= '0;
                    state   <= S_WAIT_START;
                end
                S_WAIT_START: begin
                    if (clk_fall) begin
                        dat_low <= ~cmd_q[0];
                        bit_idx <= 4'd1;
                        cnt     <= '0;
                        state   <= S_SHIFT;
                    end else if (cnt == START_LAST) begin
                        state                         <= S_ERROR;
                        error_communication_timed_out <= 1'b1;
                        busy                          <= 1'b0;
                        clk_low                       <= 1'b0;
                        dat_low                       <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_SHIFT: begin
                    if (cnt == XFER_LAST) begin
                        state                         <= S_ERROR;
                        error_communication_timed_out <= 1'b1;
                        busy                          <= 1'b0;
                        clk_low                       <= 1'b0;
                        dat_low                       <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                        if (clk_fall) begin
                            bit_idx <= bit_idx + 4'd1;
                            if (bit_idx == 4'd9) begin
                                dat_low <= 1'b0;
                                state   <= S_WAIT_ACK;
                            end else begin
                                dat_low <= ~frame_bit;
                            end
                        end
                    end
                end
                S_WAIT_ACK: begin
                    if (cnt == XFER_LAST || (clk_fall && dat_s)) begin
                        state                         <= S_ERROR;
                        error_communication_timed_out <= 1'b1;
                        busy                          <= 1'b0;
                        clk_low                       <= 1'b0;
                        dat_low                       <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                        if (clk_fall) begin
                            state <= S_WAIT_IDLE;
                        end
                    end
                end
                S_WAIT_IDLE: begin
                    if (cnt == XFER_LAST) begin
                        state                         <= S_ERROR;
                        error_communication_timed_out <= 1'b1;
                        busy                          <= 1'b0;
                        clk_low                       <= 1'b0;
                        dat_low                       <= 1'b0;
                    end else if (clk_s && dat_s) begin
                        command_was_sent <= 1'b1;
                        busy             <= 1'b0;
                        cnt              <= '0;
                        bit_idx          <= '0;
                        state            <= S_IDLE;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_ERROR: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    state   <= S_IDLE;
                end
                default: begin
                    clk_low <= 1'b0;
                    dat_low <= 1'b0;
                    busy    <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_command_out.sv
// tb_ps2_command_out: scoreboard bench with a PS/2 device model.
// Expected outcomes and frames are queued at request time and popped on output.
module tb_ps2_command_out;

    localparam int INH  = 60;
    localparam int STO  = 700;
    localparam int XTO  = 1000;
    localparam int SYNC = 2;
    localparam int H    = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] cmd = 8'h00;
    logic       send = 1'b0;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;
    logic       busy;
    logic       done;
    logic       err;
    wire        ps2_clk;
    wire        ps2_dat;

    pullup (ps2_clk);
    pullup (ps2_dat);
    assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
    assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;

    ps2_command_out #(
        .INHIBIT_CYCLES(INH),
        .START_TIMEOUT (STO),
        .XFER_TIMEOUT  (XTO),
        .SYNC_STAGES   (SYNC)
    ) dut (
        .CLOCK_50                      (clk),
        .resetn                        (rst_n),
        .the_command                   (cmd),
        .send_command                  (send),
        .PS2_CLK                       (ps2_clk),
        .PS2_DAT                       (ps2_dat),
        .busy                          (busy),
        .command_was_sent              (done),
        .error_communication_timed_out (err)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // 2'b01 = command_was_sent, 2'b10 = timeout/NACK error
    logic [1:0]  out_q[$];
    logic [10:0] frm_q[$];
    int          done_cyc = 0;
    int          err_cyc = 0;
    logic        prev_pulse = 1'b0;

    always @(negedge clk) begin
        if (done || err) begin
            check("excl", 32'(done & err), 0);
            check("pulse_w", 32'(prev_pulse), 0);
            check("busy_at_pulse", 32'(busy), 0);
            if (out_q.size() == 0) check("spurious", 32'({err, done}), 0);
            else check("outcome", 32'({err, done}), 32'(out_q.pop_front()));
            if (done) done_cyc = cyc;
            if (err) err_cyc = cyc;
        end
        prev_pulse = done | err;
    end

    task automatic do_xfer(input logic [7:0] c, input int nfall, input bit nack,
                           input bit dup, input bit rst_mid);
        logic [10:0] frame;
        int          n_dat;
        int          n_clk;
        int          c_rel;
        int          c_drop;
        int          lows;
        frame  = '0;
        n_dat  = -1;
        n_clk  = -1;
        c_drop = 0;
        if (!rst_mid) out_q.push_back((nfall == 11 && !nack) ? 2'b01 : 2'b10);
        if (nfall >= 10) frm_q.push_back({1'b1, ~^c, c, 1'b0});

        @(negedge clk);
        cmd  = c;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        cmd  = 8'hA5;
        check("busy_rise", 32'(busy), 1);

        for (int n = 0; n < INH + 10; n++) begin
            if (n_dat < 0 && ps2_dat == 1'b0) n_dat = n;
            if (ps2_clk == 1'b1) begin
                n_clk = n;
                break;
            end
            @(negedge clk);
        end
        check("inh_dat", 32'(n_dat), INH);
        check("inh_clk", 32'(n_clk), INH + 1);
        c_rel    = cyc;
        frame[0] = ps2_dat;

        for (int i = 1; i <= nfall && i <= 10; i++) begin
            repeat (H) @(negedge clk);
            if (i == 1) c_drop = cyc;
            dev_clk_low = 1'b1;
            if (dup && i == 3) begin
                cmd  = 8'h5A;
                send = 1'b1;
                @(negedge clk);
                send = 1'b0;
                repeat (H - 1) @(negedge clk);
            end else begin
                repeat (H) @(negedge clk);
            end
            frame[i]    = ps2_dat;
            dev_clk_low = 1'b0;
        end

        if (rst_mid) begin
            check("rst_pre_dat", 32'(ps2_dat), 0);
            rst_n = 1'b0;
            #1;
            check("rst_clk_rel", 32'(ps2_clk), 1);
            check("rst_dat_rel", 32'(ps2_dat), 1);
            check("rst_busy", 32'(busy), 0);
            repeat (5) @(negedge clk);
            rst_n = 1'b1;
            repeat (INH) @(negedge clk);
            check("rst_idle", 32'({busy, ps2_clk, ps2_dat}), 32'(3'b011));
            return;
        end

        if (nfall == 11) begin
            repeat (H / 2) @(negedge clk);
            if (!nack) dev_dat_low = 1'b1;
            repeat (H / 2) @(negedge clk);
            dev_clk_low = 1'b1;
            repeat (H) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (H / 2) @(negedge clk);
            dev_dat_low = 1'b0;
        end
        if (nfall >= 10) check("frame", 32'(frame), 32'(frm_q.pop_front()));

        for (int k = 0; k < STO + XTO + 100 && busy; k++) @(negedge clk);
        check("drain", 32'(busy), 0);
        @(negedge clk);
        check("clk_rel", 32'(ps2_clk), 1);
        check("dat_rel", 32'(ps2_dat), 1);
        if (nfall == 0) check("start_to", 32'(err_cyc - c_rel), STO);
        if (nfall > 0 && nfall < 10)
            check("xfer_to", 32'(err_cyc - c_drop), XTO + SYNC + 1);

        if (dup) begin
            lows = 0;
            repeat (INH + 20) begin
                @(negedge clk);
                if (ps2_clk == 1'b0) lows++;
            end
            check("no_2nd", 32'(lows), 0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy0", 32'(busy), 0);
        check("rst_pulses", 32'({done, err}), 0);
        check("rst_lines", 32'({ps2_clk, ps2_dat}), 32'(2'b11));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        do_xfer(8'hED, 11, 1'b0, 1'b1, 1'b0);
        do_xfer(8'h00, 11, 1'b1, 1'b0, 1'b0);
        do_xfer(8'hF4, 11, 1'b0, 1'b0, 1'b0);
        do_xfer(8'hFF, 0,  1'b0, 1'b0, 1'b0);
        do_xfer(8'hED, 5,  1'b0, 1'b0, 1'b0);
        do_xfer(8'h00, 3,  1'b0, 1'b0, 1'b1);
        do_xfer(8'h00, 11, 1'b0, 1'b0, 1'b0);

        repeat (5) @(negedge clk);
        check("sb_empty", 32'(out_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, failed so far %0d", n_fail);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ps2_command_out.md
Name: ps2_command_out

Overview:
Host-to-device PS/2 transmitter. It sends one 8-bit command byte (e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable) from the FPGA to the keyboard using the PS/2 host-request protocol. It shares the PS2_CLK/PS2_DAT lines with the existing scan-code receiver and reports success or timeout.

Parameters:
INHIBIT_CYCLES, 6000, cycles PS2_CLK is held low before the request-to-send (120 us at 50 MHz).
START_TIMEOUT, 750000, maximum cycles from clock release to the first device falling edge (15 ms).
XFER_TIMEOUT, 100000, maximum cycles from the first device falling edge to ACK (2 ms).
SYNC_STAGES, 2, flip-flop stages used to synchronise the PS2_CLK and PS2_DAT inputs.

Ports:
CLOCK_50  input  1  system clock; the only clock in the block.
resetn  input  1  asynchronous, active-low reset.
the_command  input  8  command byte; sampled when a request is accepted.
send_command  input  1  request strobe; a single-cycle high is enough.
PS2_CLK  inout  1  PS/2 clock line; open-drain, either driven 0 or left at 'z'.
PS2_DAT  inout  1  PS/2 data line; open-drain, either driven 0 or left at 'z'.
busy  output  1  high from request acceptance until the done or error pulse.
command_was_sent  output  1  one-cycle pulse when the device ACK is received and both lines are back high.
error_communication_timed_out  output  1  one-cycle pulse on timeout or missing ACK.

Behaviour:
- Reset: the state is IDLE, both lines are released ('z'), busy=0, command_was_sent=0, error=0, and all counters are 0. Asserting resetn mid-transfer releases both lines immediately (asynchronously) and aborts the transfer with no pulse.
- Input conditioning: PS2_CLK and PS2_DAT are synchronised through SYNC_STAGES flops. A falling edge is detected on the synchronised clock (previous value 1, current value 0), and one pulse is produced per edge.
- Accept: in IDLE with send_command=1, the block latches the_command and computes parity = ~^the_command (odd parity). It then goes to INHIBIT, and busy rises on the next cycle. send_command is ignored whenever the state is not IDLE.
- INHIBIT: drive PS2_CLK=0 and release PS2_DAT for INHIBIT_CYCLES cycles, then go to RTS.
- RTS: one cycle driving both lines 0; this is the start bit. Then go to WAIT_START.
- WAIT_START: release PS2_CLK and keep PS2_DAT=0.
  - First falling edge: drive data bit 0 and set bit_idx=1. Go to SHIFT.
  - START_TIMEOUT cycles with no falling edge: go to ERROR.
- SHIFT: on each falling edge, bit_idx selects what is presented on PS2_DAT.
  - bit_idx 1..7: data bits 1..7, LSB first.
  - bit_idx 8: parity.
  - bit_idx 9: release PS2_DAT (stop bit). Go to WAIT_ACK.
  - Driving a '1' always means releasing the line to 'z'. The line is never driven high.
- WAIT_ACK: on the next falling edge, sample the synchronised PS2_DAT.
  - Sampled 0: go to WAIT_IDLE.
  - Sampled 1: NACK, go to ERROR.
- WAIT_IDLE: wait until the synchronised PS2_CLK and PS2_DAT are both 1. Then pulse command_was_sent and drop busy in the same cycle, and return to IDLE.
- Transfer timer: cleared at the first falling edge and counts through SHIFT, WAIT_ACK and WAIT_IDLE. Reaching XFER_TIMEOUT in any of these states goes to ERROR.
- ERROR: one cycle. Both lines are released, error_communication_timed_out=1, busy drops, and the state returns to IDLE.
- Timing: the done pulse and the error pulse never occur together. Each pulse is exactly one CLOCK_50 cycle.
- Timeout comparisons: at count == limit-1 (registered), so timeout occurs exactly limit cycles after the counter starts.
- Coexistence with the receiver: the receiver tolerates this traffic, and the top level gates its received_data_en while busy=1.

Test Plan:
1. Nominal 0xED: request, and the device model clocks at 12.5 kHz with ACK. The bits seen on PS2_DAT at the 11 device rising edges must be 0,1,0,1,1,0,1,1,1,1,1: start, 0xED LSB-first, parity=1, stop. Then command_was_sent pulses once and busy=0.
2. Inhibit timing: after send_command, PS2_CLK must be low for exactly 6000 cycles. PS2_DAT goes low on cycle 6000 and PS2_CLK is released on cycle 6001.
3. No device: after clock release no edges arrive. The error pulse must occur exactly 750000 cycles after release, with both lines 'z' and busy=0.
4. NACK: the device leaves PS2_DAT high on the 11th clock. Expect the error pulse and no command_was_sent. Send 0x00 (parity=1) in the same run.
5. Stall mid-byte: the device stops clocking after 5 edges. Expect the error pulse 100000 cycles after the first edge, with both lines released.
6. Reset and ignored requests: assert resetn=0 during SHIFT; both lines must read 'z' before the next CLOCK_50 edge, with no pulses. Send a second send_command while busy; it must produce no second transfer.
